execute_stage: RTL
==================

Name: execute_stage

Overview:
Pipeline EX stage of the 5-stage RV32I core, together with the EX/MEM pipeline register.
- Consumes ID/EX register fields and the ForwardAE/ForwardBE selects produced by hazard_unit.
- Selects forwarded operands, runs the ALU, and resolves branches and jumps.
- Registers the result into the M stage. Its RD_M/RegWriteM outputs feed back into hazard_unit.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_M  in  1  hold EX/MEM register (memory wait)
valid_E  in  1  EX holds a real instruction (0 = bubble)
RD1_E  in  XLEN  register-file operand 1
RD2_E  in  XLEN  register-file operand 2
Imm_Ext_E  in  XLEN  sign-extended immediate
PC_E  in  XLEN  instruction PC
PCPlus4_E  in  XLEN  PC+4
RD_E  in  REG_AW  destination register
RegWriteE  in  1  write-back enable
MemWriteE  in  1  store enable
ResultSrcE  in  2  WB mux select (00 ALU, 01 mem, 10 PC+4)
ALUSrcE  in  1  0 = forwarded B, 1 = immediate
ALUControlE  in  3  ALU opcode
BranchE  in  1  conditional branch
BranchNeE  in  1  0 = beq, 1 = bne
JumpE  in  1  jal
ForwardAE  in  2  operand-A select (from hazard_unit)
ForwardBE  in  2  operand-B select (from hazard_unit)
ResultW  in  XLEN  WB-stage result for forwarding
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  XLEN  PC_E + Imm_Ext_E (combinational)
RegWriteM  out  1  registered
MemWriteM  out  1  registered
ResultSrcM  out  2  registered
RD_M  out  REG_AW  registered
ALU_ResultM  out  XLEN  registered
WriteDataM  out  XLEN  registered store data
PCPlus4M  out  XLEN  registered

Behaviour:
- Operand A select by ForwardAE:
  - 00: RD1_E
  - 01: ResultW
  - 10: ALU_ResultM (internal feedback)
  - 11: reserved, treated as 00
- Forwarded B is selected the same way by ForwardBE, from RD2_E. SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- ALU ops:
  - 000 add; 001 sub; 010 and; 011 or; 100 xor
  - 101 slt: signed, result 1/0 zero-extended
  - 110 sll, 111 srl: shift amount is SrcB[4:0] only
  - Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Zero = (ALU result == 0), computed with ALUControlE = sub for branches.
- PCSrcE = valid_E & (JumpE | (BranchE & (Zero ^ BranchNeE))). It is 0 whenever valid_E = 0.
- EX/MEM register, one-cycle latency; priority is rst > stall_M > capture.
  - rst: all registered outputs go to 0 on the next edge, including when rst arrives mid-stall.
  - stall_M = 1: every registered output holds. The held ALU_ResultM remains the 10-forward source.
  - Capture with valid_E = 1: all fields loaded. WriteDataM = forwarded B (pre-ALUSrc mux). RD_M = RD_E.
  - Capture with valid_E = 0: bubble. RegWriteM = MemWriteM = 0, ResultSrcM = 00, all other fields 0.
- PCSrcE/PCTargetE are unaffected by stall_M. Upstream stages gate the redirect.
- No internal state besides the EX/MEM register; no X propagation from reset onward.

Decomposition:
- Shared package pipeline_pkg: ALU opcode constants, FWD_NONE/FWD_WB/FWD_MEM, ResultSrc encodings, XLEN default. hazard_unit also uses this package.
- One sub-module, alu: purely combinational; inputs a, b, ctrl; outputs result, zero.
- Forward muxes, branch logic and the EX/MEM register stay in execute_stage.

Test Plan:
1. Reset: drive valid add with RegWriteE = 1 and rst = 1 for 2 cycles → all M outputs 0. Assert rst during stall_M = 1 → outputs 0 on the next edge.
2. MEM forward: ALU_ResultM = 5; RD1_E = 99, ForwardAE = 10, RD2_E = 7, ForwardBE = 00, add → ALU_ResultM = 12. ForwardAE = 11 with the same data → 106.
3. WB forward on store: ResultW = 0x20, ForwardBE = 01, ALUSrcE = 1, Imm = 4, RD1_E = 0x100, MemWriteE = 1 → ALU_ResultM = 0x104, WriteDataM = 0x20, MemWriteM = 1.
4. Branch: RD1_E = RD2_E = 3, beq, PC_E = 0x40, Imm = 0xFFFFFFF8 → PCSrcE = 1, PCTargetE = 0x38. With BranchNeE = 1 → PCSrcE = 0. With valid_E = 0 → PCSrcE = 0 and a bubble is registered.
5. Stall: capture a result, then hold stall_M = 1 for 3 cycles while inputs change → outputs unchanged. Release → next edge captures the current inputs.
6. ALU edges:
   - slt 0xFFFFFFFF vs 1 → 1.
   - srl 0x80000000 by SrcB = 33 → 0x40000000.
   - add 0xFFFFFFFF + 1 → 0.
   - sub 0 − 1 → 0xFFFFFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU opcodes, forwarding selects, WB mux
// encodings and the default datapath width. Also used by hazard_unit.
package pipeline_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    // 2'b11 is reserved and falls back to the register-file operand.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU with a zero flag for branch compare.
module alu
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic lt;

    // Evaluate the selected operation; arithmetic wraps, shifts use low bits of b only.
    always_comb begin
        result = '0;
        lt     = ($signed(a) < $signed(b));
        case (alu_op_t'(ctrl))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLL: result = a << b[SHW-1:0];
            ALU_SRL: result = a >> b[SHW-1:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline plus the EX/MEM pipeline register.
// Forwards operands, runs the ALU, resolves branches/jumps, registers into M.
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_M,
    input  logic              valid_E,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PC_E,
    input  logic [XLEN-1:0]   PCPlus4_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              ALUSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic              BranchE,
    input  logic              BranchNeE,
    input  logic              JumpE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   ALU_ResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Operand A forwarding; the reserved select behaves like no forwarding.
    always_comb begin
        src_a = RD1_E;
        case (fwd_t'(ForwardAE))
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    // Operand B forwarding; this value is also the store data.
    always_comb begin
        fwd_b = RD2_E;
        case (fwd_t'(ForwardBE))
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a      (src_a),
        .b      (src_b),
        .ctrl   (ALUControlE),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign PCTargetE = PC_E + Imm_Ext_E;
    assign PCSrcE    = valid_E & (JumpE | (BranchE & (alu_zero ^ BranchNeE)));

    // EX/MEM register: reset beats stall, stall holds, bubbles load zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= RES_ALU;
            RD_M        <= '0;
            ALU_ResultM <= '0;
            WriteDataM  <= '0;
            PCPlus4M    <= '0;
        end else if (!stall_M) begin
            if (valid_E) begin
                RegWriteM   <= RegWriteE;
                MemWriteM   <= MemWriteE;
                ResultSrcM  <= ResultSrcE;
                RD_M        <= RD_E;
                ALU_ResultM <= alu_result;
                WriteDataM  <= fwd_b;
                PCPlus4M    <= PCPlus4_E;
            end else begin
                RegWriteM   <= 1'b0;
                MemWriteM   <= 1'b0;
                ResultSrcM  <= RES_ALU;
                RD_M        <= '0;
                ALU_ResultM <= '0;
                WriteDataM  <= '0;
                PCPlus4M    <= '0;
            end
        end
    end

endmodule
